// File: rtl/cpu_pkg.sv
// Shared MultiCPU definitions: ALU opcode encodings (funct-style),
// datapath width and shifter mode select.
package cpu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_ADDU = 6'b100001;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_SUBU = 6'b100011;
    localparam logic [5:0] ALU_AND  = 6'b100100;
    localparam logic [5:0] ALU_OR   = 6'b100101;
    localparam logic [5:0] ALU_XOR  = 6'b100110;
    localparam logic [5:0] ALU_NOR  = 6'b100111;
    localparam logic [5:0] ALU_SLT  = 6'b101010;
    localparam logic [5:0] ALU_SLTU = 6'b101011;
    localparam logic [5:0] ALU_SLL  = 6'b000000;
    localparam logic [5:0] ALU_SRL  = 6'b000010;
    localparam logic [5:0] ALU_SRA  = 6'b000011;
    localparam logic [5:0] ALU_SLLV = 6'b000100;
    localparam logic [5:0] ALU_SRLV = 6'b000110;
    localparam logic [5:0] ALU_SRAV = 6'b000111;
    localparam logic [5:0] ALU_LUI  = 6'b001111;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for the ALU: logical left, logical right
// and arithmetic (sign-filling) right by a log2(WIDTH)-bit amount.
module alu_shifter
    import cpu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  shift_mode_e      mode_i,
    output logic [WIDTH-1:0] result_o
);

    // Select the shift direction/fill for the requested mode.
    always_comb begin
        result_o = {WIDTH{1'b0}};
        case (mode_i)
            SH_SLL:  result_o = data_i << shamt_i;
            SH_SRL:  result_o = data_i >> shamt_i;
            SH_SRA:  result_o = $unsigned($signed(data_i) >>> shamt_i);
            default: result_o = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// EXE-stage integer ALU: combinational result every cycle, plus zero and
// signed-overflow flags registered one cycle later for control/debug.
module alu_core
    import cpu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_ALU_srcA,
    input  logic [WIDTH-1:0] i_ALU_srcB,
    input  logic [5:0]       i_ALU_op,
    output logic [WIDTH-1:0] o_ALU_aluOut,
    output logic             o_ALU_zero,
    output logic             o_ALU_ovf
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] shift_res_s;
    logic             add_ovf_s;
    logic             sub_ovf_s;
    logic             slt_s;
    logic             sltu_s;
    shift_mode_e      shift_mode_s;
    logic [WIDTH-1:0] result_s;
    logic             ovf_d;
    logic             zero_d;
    logic             zero_q;
    logic             ovf_q;

    assign sum_s  = i_ALU_srcA + i_ALU_srcB;
    assign diff_s = i_ALU_srcA - i_ALU_srcB;

    // Overflow is judged on sign bits only; the wrapped value is always output.
    assign add_ovf_s = (i_ALU_srcA[WIDTH-1] == i_ALU_srcB[WIDTH-1]) &&
                       (sum_s[WIDTH-1] != i_ALU_srcA[WIDTH-1]);
    assign sub_ovf_s = (i_ALU_srcA[WIDTH-1] != i_ALU_srcB[WIDTH-1]) &&
                       (diff_s[WIDTH-1] != i_ALU_srcA[WIDTH-1]);

    assign slt_s  = $signed(i_ALU_srcA) < $signed(i_ALU_srcB);
    assign sltu_s = i_ALU_srcA < i_ALU_srcB;

    // Shift direction from the funct low bits; V and non-V forms behave alike.
    always_comb begin
        shift_mode_s = SH_SLL;
        case (i_ALU_op[1:0])
            2'b00:   shift_mode_s = SH_SLL;
            2'b10:   shift_mode_s = SH_SRL;
            2'b11:   shift_mode_s = SH_SRA;
            default: shift_mode_s = SH_SLL;
        endcase
    end

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data_i   (i_ALU_srcB),
        .shamt_i  (i_ALU_srcA[SHW-1:0]),
        .mode_i   (shift_mode_s),
        .result_o (shift_res_s)
    );

    // Result and overflow select by opcode; unknown codes yield zero.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        ovf_d    = 1'b0;
        case (i_ALU_op)
            ALU_ADD: begin
                result_s = sum_s;
                ovf_d    = add_ovf_s;
            end
            ALU_ADDU: result_s = sum_s;
            ALU_SUB: begin
                result_s = diff_s;
                ovf_d    = sub_ovf_s;
            end
            ALU_SUBU: result_s = diff_s;
            ALU_AND:  result_s = i_ALU_srcA & i_ALU_srcB;
            ALU_OR:   result_s = i_ALU_srcA | i_ALU_srcB;
            ALU_XOR:  result_s = i_ALU_srcA ^ i_ALU_srcB;
            ALU_NOR:  result_s = ~(i_ALU_srcA | i_ALU_srcB);
            ALU_SLT:  result_s = {{(WIDTH-1){1'b0}}, slt_s};
            ALU_SLTU: result_s = {{(WIDTH-1){1'b0}}, sltu_s};
            ALU_SLL, ALU_SLLV,
            ALU_SRL, ALU_SRLV,
            ALU_SRA, ALU_SRAV: result_s = shift_res_s;
            ALU_LUI:  result_s = {i_ALU_srcB[15:0], {(WIDTH-16){1'b0}}};
            default: begin
                result_s = {WIDTH{1'b0}};
                ovf_d    = 1'b0;
            end
        endcase
    end

    assign zero_d       = (result_s == {WIDTH{1'b0}});
    assign o_ALU_aluOut = result_s;

    // Status flag capture; reset clears only the flags, never the result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_ALU_zero = zero_q;
    assign o_ALU_ovf  = ovf_q;

endmodule

// File: tb/tb_alu_core.sv
// Randomised and directed bench for alu_core against an arithmetic
// reference model of the opcode table.
module tb_alu_core;

    logic        clk;
    logic        rstn;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [5:0]  op;
    logic [31:0] alu_out;
    logic        zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    logic [5:0] legal_ops [17] = '{
        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
        6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000100,
        6'b000010, 6'b000110, 6'b000011, 6'b000111, 6'b001111
    };

    alu_core dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_ALU_srcA   (srca),
        .i_ALU_srcB   (srcb),
        .i_ALU_op     (op),
        .o_ALU_aluOut (alu_out),
        .o_ALU_zero   (zero),
        .o_ALU_ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, result} from signed/unsigned integer arithmetic.
    function automatic logic [32:0] model(input logic [5:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        int unsigned sh = 32'(a[4:0]);
        logic [31:0] r = 32'd0;
        logic v = 1'b0;
        case (o)
            6'b100000: begin s = sa + sb; r = s[31:0];
                             v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'b100001: r = a + b;
            6'b100010: begin s = sa - sb; r = s[31:0];
                             v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'b100011: r = a - b;
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = ~(a | b);
            6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
            6'b101011: r = (a < b) ? 32'd1 : 32'd0;
            6'b000000, 6'b000100: r = b * (32'd1 << sh);
            6'b000010, 6'b000110: r = b / (32'd1 << sh);
            6'b000011, 6'b000111: begin s = sb >>> sh; r = s[31:0]; end
            6'b001111: r = b * 32'h0001_0000;
            default: r = 32'd0;
        endcase
        return {v, r};
    endfunction

    // Drive one op, check the combinational result, then the flags after the edge.
    task automatic apply(input string tag, input logic [5:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        logic [32:0] m;
        @(negedge clk);
        op = o; srca = a; srcb = b;
        m = model(o, a, b);
        #1;
        chk({tag, ".res"}, alu_out, m[31:0]);
        @(posedge clk);
        #1;
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, (m[31:0] == 32'd0)});
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, m[32]});
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  o;
        rstn = 1'b0; op = 6'b100000; srca = 32'h7FFF_FFFF; srcb = 32'd1;
        #1;
        chk("reset.zero", {31'd0, zero}, 32'd0);
        chk("reset.ovf", {31'd0, ovf}, 32'd0);
        chk("reset.res", alu_out, 32'h8000_0000);
        @(posedge clk); #1;
        chk("reset.hold_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Directed cases with hand-derived expectations.
        apply("add_ovf", 6'b100000, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_ovf.flag", {31'd0, ovf}, 32'd1);
        chk("add_ovf.val", alu_out, 32'h8000_0000);
        apply("addu", 6'b100001, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("addu.flag", {31'd0, ovf}, 32'd0);
        apply("sub_zero", 6'b100010, 32'd5, 32'd5);
        chk("sub_zero.flag", {31'd0, zero}, 32'd1);
        apply("sub_ovf", 6'b100010, 32'h8000_0000, 32'd1);
        chk("sub_ovf.val", alu_out, 32'h7FFF_FFFF);
        chk("sub_ovf.flag", {31'd0, ovf}, 32'd1);
        apply("slt", 6'b101010, 32'hFFFF_FFFF, 32'd1);
        chk("slt.val", alu_out, 32'd1);
        apply("sltu", 6'b101011, 32'hFFFF_FFFF, 32'd1);
        chk("sltu.val", alu_out, 32'd0);
        apply("and", 6'b100100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk("and.val", alu_out, 32'h00F0_00F0);
        apply("or", 6'b100101, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk("or.val", alu_out, 32'hFFF0_FFF0);
        apply("xor", 6'b100110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk("xor.val", alu_out, 32'hFF00_FF00);
        apply("nor", 6'b100111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk("nor.val", alu_out, 32'h000F_000F);
        apply("sll", 6'b000000, 32'd4, 32'h8000_0010);
        chk("sll.val", alu_out, 32'h0000_0100);
        apply("srl", 6'b000010, 32'd4, 32'h8000_0010);
        chk("srl.val", alu_out, 32'h0800_0001);
        apply("sra", 6'b000011, 32'd4, 32'h8000_0010);
        chk("sra.val", alu_out, 32'hF800_0001);
        apply("srav", 6'b000111, 32'h24, 32'h8000_0010);
        chk("srav.val", alu_out, 32'hF800_0001);
        apply("sll0", 6'b000100, 32'hFFFF_FFE0, 32'h1234_5678);
        chk("sll0.val", alu_out, 32'h1234_5678);
        apply("lui", 6'b001111, 32'd0, 32'h0000_1234);
        chk("lui.val", alu_out, 32'h1234_0000);
        apply("illegal", 6'b111111, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("illegal.val", alu_out, 32'd0);
        chk("illegal.zero", {31'd0, zero}, 32'd1);

        // Mid-operation reset: flags drop at once, result keeps tracking inputs.
        apply("rst_pre", 6'b100000, 32'h7FFF_FFFF, 32'd1);
        @(negedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("midrst.ovf", {31'd0, ovf}, 32'd0);
        chk("midrst.zero", {31'd0, zero}, 32'd0);
        chk("midrst.res", alu_out, 32'h8000_0000);
        srcb = 32'd2;
        #1;
        chk("midrst.track", alu_out, 32'h8000_0001);
        @(posedge clk); #1;
        chk("midrst.held", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rel.before_edge", {31'd0, ovf}, 32'd0);
        @(posedge clk); #1;
        chk("rel.ovf", {31'd0, ovf}, 32'd1);
        chk("rel.zero", {31'd0, zero}, 32'd0);

        // Randomised sweep, biased toward sign/overflow boundaries.
        for (int i = 0; i < 400; i++) begin
            o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 16)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h7FFF_FFFF;
                1: b = 32'h8000_0000;
                2: b = a;
                default: a = a;
            endcase
            apply("rand", o, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
